// File: rtl/ddfs_sweep_ctrl_if.sv
// ----------------------------------------------------------------------------
// ddfs_sweep_ctrl_if
//   Bundles the sweep sequencer's configuration, control strobes and the
//   outputs it drives towards the ddfs core.
//
//   master : register-bank side. Drives the config and strobes, observes
//            the sweep outputs.
//   slave  : sequencer side (ddfs_sweep_ctrl).
//
//   Signals
//     start, abort  one-cycle control strobes
//     rpt           repeat the sweep after the terminal word
//     start_fccw    first frequency word
//     stop_fccw     last permissible frequency word (inclusive)
//     step_fccw     unsigned increment per step
//     dwell         each word is held for dwell+1 cycles
//     fccw, env     frequency word and envelope sent to ddfs
//     busy          sweep running
//     done_tick     single-cycle completion pulse (non-repeat sweeps only)
// ----------------------------------------------------------------------------
interface ddfs_sweep_ctrl_if #(
  parameter int PW = 26,
  parameter int DW = 16
);
  logic          start;
  logic          abort;
  logic          rpt;
  logic [PW-1:0] start_fccw;
  logic [PW-1:0] stop_fccw;
  logic [PW-1:0] step_fccw;
  logic [DW-1:0] dwell;
  logic [PW-1:0] fccw;
  logic [15:0]   env;
  logic          busy;
  logic          done_tick;

  modport master (
    output start, abort, rpt, start_fccw, stop_fccw, step_fccw, dwell,
    input  fccw, env, busy, done_tick
  );

  modport slave (
    input  start, abort, rpt, start_fccw, stop_fccw, step_fccw, dwell,
    output fccw, env, busy, done_tick
  );
endinterface

// File: rtl/ddfs_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// ddfs_sweep_ctrl
//   Linear frequency-sweep sequencer for the ddfs unit. On a start strobe it
//   latches the sweep configuration and steps fccw from start_fccw towards
//   stop_fccw in increments of step_fccw, holding each word for dwell+1
//   clock cycles. The envelope is driven to ENV_ON while the sweep runs and
//   to zero otherwise.
//
//   Ports
//     clk    : system clock, rising edge
//     reset  : asynchronous, active-high reset
//     bus    : ddfs_sweep_ctrl_if.slave
//              inputs : start, abort, rpt, start_fccw, stop_fccw,
//                       step_fccw, dwell
//              outputs: fccw, env, busy, done_tick (all registered)
//
//   Notes
//     - abort has priority over start in idle and over any step or
//       terminal event in run.
//     - The next-word compare uses a PW+1-bit sum, so a word close to the
//       top of the range can never wrap around to a small value.
//     - Configuration inputs are only sampled on an accepted start.
// ----------------------------------------------------------------------------
module ddfs_sweep_ctrl #(
  parameter int          PW     = 26,
  parameter int          DW     = 16,
  parameter logic [15:0] ENV_ON = 16'h7fff
) (
  input  logic                 clk,
  input  logic                 reset,
  ddfs_sweep_ctrl_if.slave     bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state_r;

  // Output registers
  logic [PW-1:0] fccw_r;
  logic [15:0]   env_r;
  logic          busy_r;
  logic          done_tick_r;

  // Dwell counter and configuration latched at start
  logic [DW-1:0] cnt_r;
  logic [PW-1:0] start_l_r;
  logic [PW-1:0] stop_l_r;
  logic [PW-1:0] step_l_r;
  logic [DW-1:0] dwell_l_r;
  logic          rpt_l_r;

  // Next-word evaluation
  logic [PW:0]   next_sum_s;
  logic          adv_ok_s;
  logic          dwell_end_s;
  logic          start_go_s;

  // Next-word sum, advance permission and end-of-dwell detection.
  always_comb begin
    next_sum_s  = {1'b0, fccw_r} + {1'b0, step_l_r};
    adv_ok_s    = 1'b0;
    dwell_end_s = 1'b0;
    start_go_s  = 1'b0;
    // A zero step would hold forever without progress; treat it as terminal.
    if ((next_sum_s <= {1'b0, stop_l_r}) && (step_l_r != {PW{1'b0}})) begin
      adv_ok_s = 1'b1;
    end else begin
      adv_ok_s = 1'b0;
    end
    if (cnt_r == dwell_l_r) begin
      dwell_end_s = 1'b1;
    end else begin
      dwell_end_s = 1'b0;
    end
    if (bus.start && !bus.abort) begin
      start_go_s = 1'b1;
    end else begin
      start_go_s = 1'b0;
    end
  end

  // Sweep state machine with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      fccw_r      <= {PW{1'b0}};
      env_r       <= 16'h0000;
      busy_r      <= 1'b0;
      done_tick_r <= 1'b0;
      cnt_r       <= {DW{1'b0}};
      start_l_r   <= {PW{1'b0}};
      stop_l_r    <= {PW{1'b0}};
      step_l_r    <= {PW{1'b0}};
      dwell_l_r   <= {DW{1'b0}};
      rpt_l_r     <= 1'b0;
    end else begin
      // done_tick is a single-cycle pulse unless re-asserted below.
      done_tick_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_go_s) begin
            start_l_r <= bus.start_fccw;
            stop_l_r  <= bus.stop_fccw;
            step_l_r  <= bus.step_fccw;
            dwell_l_r <= bus.dwell;
            rpt_l_r   <= bus.rpt;
            fccw_r    <= bus.start_fccw;
            cnt_r     <= {DW{1'b0}};
            env_r     <= ENV_ON;
            busy_r    <= 1'b1;
            state_r   <= ST_RUN;
          end else begin
            // fccw keeps the last word of the previous sweep.
            state_r   <= ST_IDLE;
          end
        end

        ST_RUN: begin
          if (bus.abort) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            env_r   <= 16'h0000;
            cnt_r   <= {DW{1'b0}};
          end else if (dwell_end_s) begin
            cnt_r <= {DW{1'b0}};
            if (adv_ok_s) begin
              fccw_r <= next_sum_s[PW-1:0];
            end else if (rpt_l_r) begin
              fccw_r <= start_l_r;
            end else begin
              // Terminal word of a single sweep: fccw holds its final value.
              state_r     <= ST_IDLE;
              busy_r      <= 1'b0;
              env_r       <= 16'h0000;
              done_tick_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + {{(DW-1){1'b0}}, 1'b1};
          end
        end

        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          env_r   <= 16'h0000;
          cnt_r   <= {DW{1'b0}};
        end
      endcase
    end
  end

  assign bus.fccw      = fccw_r;
  assign bus.env       = env_r;
  assign bus.busy      = busy_r;
  assign bus.done_tick = done_tick_r;

endmodule

// File: tb/tb_ddfs_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ddfs_sweep_ctrl
//   Table-driven, self-checking bench for ddfs_sweep_ctrl. Each table entry
//   holds the inputs for one clock cycle and the outputs expected after that
//   edge; expectations go through a scoreboard queue. A hand-written sequence
//   covers the asynchronous reset in the middle of a sweep.
// ----------------------------------------------------------------------------
module tb_ddfs_sweep_ctrl;
  localparam int PW = 26;
  localparam int DW = 16;
  localparam logic [15:0] ENV_ON = 16'h7fff;

  logic clk;
  logic reset;

  ddfs_sweep_ctrl_if #(.PW(PW), .DW(DW)) intf ();

  ddfs_sweep_ctrl #(.PW(PW), .DW(DW), .ENV_ON(ENV_ON)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          start;
    logic          abort;
    logic          rpt;
    logic [PW-1:0] sf;
    logic [PW-1:0] pf;
    logic [PW-1:0] tf;
    logic [DW-1:0] dw;
    logic [PW-1:0] e_fccw;
    logic          e_on;
    logic          e_done;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  int checks = 0;
  int errors = 0;

  logic          cfg_rpt;
  logic [PW-1:0] cfg_sf, cfg_pf, cfg_tf;
  logic [DW-1:0] cfg_dw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cfg(input logic r, input logic [PW-1:0] s, input logic [PW-1:0] p,
                     input logic [PW-1:0] t, input logic [DW-1:0] d);
    cfg_rpt = r; cfg_sf = s; cfg_pf = p; cfg_tf = t; cfg_dw = d;
  endtask

  task automatic add(input logic st, input logic ab, input logic [PW-1:0] ef,
                     input logic on, input logic dn);
    vec_t v;
    v.start = st; v.abort = ab; v.rpt = cfg_rpt;
    v.sf = cfg_sf; v.pf = cfg_pf; v.tf = cfg_tf; v.dw = cfg_dw;
    v.e_fccw = ef; v.e_on = on; v.e_done = dn;
    tbl.push_back(v);
  endtask

  task automatic drive_idle();
    intf.start = 1'b0; intf.abort = 1'b0; intf.rpt = 1'b0;
    intf.start_fccw = '0; intf.stop_fccw = '0; intf.step_fccw = '0; intf.dwell = '0;
  endtask

  task automatic chk_out(input string tag, input logic [PW-1:0] ef, input logic on, input logic dn);
    chk({tag, ".fccw"}, 32'(intf.fccw), 32'(ef));
    chk({tag, ".env"},  32'(intf.env),  on ? 32'h0000_7fff : 32'h0000_0000);
    chk({tag, ".busy"}, 32'(intf.busy), 32'(on));
    chk({tag, ".done"}, 32'(intf.done_tick), 32'(dn));
  endtask

  initial begin
    vec_t v;
    vec_t e;

    drive_idle();
    reset = 1'b1;
    #12;
    chk_out("reset", 26'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // ---- Build the vector table ----
    // Idle after reset
    cfg(1'b0, 26'd0, 26'd0, 26'd0, 16'd0);
    add(1'b0, 1'b0, 26'd0, 1'b0, 1'b0);

    // Scenario 1: basic sweep 100..130 step 10 dwell 2
    cfg(1'b0, 26'd100, 26'd130, 26'd10, 16'd2);
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 3; k++)
        add((w == 0 && k == 0), 1'b0, 26'd100 + 26'(10 * w), 1'b1, 1'b0);
    add(1'b0, 1'b0, 26'd130, 1'b0, 1'b1);
    add(1'b0, 1'b0, 26'd130, 1'b0, 1'b0);

    // Scenario 5: same sweep with a second start and config changes mid-sweep
    cfg(1'b0, 26'd100, 26'd130, 26'd10, 16'd2);
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 3; k++) begin
        if (w == 1 && k == 0) cfg(1'b1, 26'd7, 26'd105, 26'd1, 16'd0);
        add((w == 0 && k == 0) || (w == 1 && k == 1), 1'b0,
            26'd100 + 26'(10 * w), 1'b1, 1'b0);
      end
    add(1'b0, 1'b0, 26'd130, 1'b0, 1'b1);
    add(1'b0, 1'b0, 26'd130, 1'b0, 1'b0);

    // Scenario 2: non-exact stop, 30 is never driven
    cfg(1'b0, 26'd0, 26'd25, 26'd10, 16'd0);
    add(1'b1, 1'b0, 26'd0,  1'b1, 1'b0);
    add(1'b0, 1'b0, 26'd10, 1'b1, 1'b0);
    add(1'b0, 1'b0, 26'd20, 1'b1, 1'b0);
    add(1'b0, 1'b0, 26'd20, 1'b0, 1'b1);
    add(1'b0, 1'b0, 26'd20, 1'b0, 1'b0);

    // Scenario 3: overflow guard near the top of the range
    cfg(1'b0, 26'h3FFFFF0, 26'h3FFFFFF, 26'd16, 16'd1);
    add(1'b1, 1'b0, 26'h3FFFFF0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 26'h3FFFFF0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 26'h3FFFFF0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 26'h3FFFFF0, 1'b0, 1'b0);

    // start > stop: one word held dwell+1 cycles
    cfg(1'b0, 26'd50, 26'd40, 26'd5, 16'd1);
    add(1'b1, 1'b0, 26'd50, 1'b1, 1'b0);
    add(1'b0, 1'b0, 26'd50, 1'b1, 1'b0);
    add(1'b0, 1'b0, 26'd50, 1'b0, 1'b1);

    // step = 0, single sweep: terminal after the first dwell
    cfg(1'b0, 26'd7, 26'd100, 26'd0, 16'd0);
    add(1'b1, 1'b0, 26'd7, 1'b1, 1'b0);
    add(1'b0, 1'b0, 26'd7, 1'b0, 1'b1);

    // Scenario 4: repeat, then abort while fccw = 10
    cfg(1'b1, 26'd0, 26'd20, 26'd10, 16'd0);
    add(1'b1, 1'b0, 26'd0,  1'b1, 1'b0);
    add(1'b0, 1'b0, 26'd10, 1'b1, 1'b0);
    add(1'b0, 1'b0, 26'd20, 1'b1, 1'b0);
    add(1'b0, 1'b0, 26'd0,  1'b1, 1'b0);
    add(1'b0, 1'b0, 26'd10, 1'b1, 1'b0);
    add(1'b0, 1'b1, 26'd10, 1'b0, 1'b0);
    // start and abort together in idle: stays idle
    add(1'b1, 1'b1, 26'd10, 1'b0, 1'b0);
    add(1'b0, 1'b0, 26'd10, 1'b0, 1'b0);

    // step = 0 with repeat: start word held indefinitely until abort
    cfg(1'b1, 26'd9, 26'd5, 26'd0, 16'd0);
    add(1'b1, 1'b0, 26'd9, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) add(1'b0, 1'b0, 26'd9, 1'b1, 1'b0);
    add(1'b0, 1'b1, 26'd9, 1'b0, 1'b0);

    // ---- Apply the table; scoreboard compares after each edge ----
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      v = tbl[i];
      intf.start = v.start; intf.abort = v.abort; intf.rpt = v.rpt;
      intf.start_fccw = v.sf; intf.stop_fccw = v.pf;
      intf.step_fccw = v.tf; intf.dwell = v.dw;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk_out($sformatf("vec%0d", i), e.e_fccw, e.e_on, e.e_done);
    end

    // ---- Scenario 6: asynchronous reset in the middle of a sweep ----
    @(negedge clk);
    intf.start = 1'b1; intf.abort = 1'b0; intf.rpt = 1'b0;
    intf.start_fccw = 26'd100; intf.stop_fccw = 26'd130;
    intf.step_fccw = 26'd10; intf.dwell = 16'd2;
    @(posedge clk);
    #1;
    chk_out("mid.start", 26'd100, 1'b1, 1'b0);
    intf.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("mid.run", 26'd110, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_out("mid.rst", 26'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk_out($sformatf("post_rst%0d", k), 26'd0, 1'b0, 1'b0);
    end
    @(negedge clk);
    intf.start = 1'b1;
    @(posedge clk);
    #1;
    chk_out("restart", 26'd100, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
